// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU pushes bytes into a small TX FIFO,
// a serializer drains it onto tx. Read data is registered (one-cycle latency).
module uart_tx_mmio #(
   parameter logic [31:0] BASE_MEMORY  = 32'hFFFF_FFE0,
   parameter logic [31:0] TOP_MEMORY   = 32'hFFFF_FFE7,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] memAddress,
   input  logic [31:0] memWriteData,
   input  logic        memWrite,
   input  logic [3:0]  byteMask,
   output logic [31:0] memReadData,
   output logic        tx,
   output logic        irq_empty
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [PW:0]   DEPTH_C   = (PW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;

   logic [7:0]    fifo_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW:0]   count_q;
   logic          overflow_q;
   logic [31:0]   read_q;

   logic sel, offset, push_req, push_ok, pop, ovf_clr;
   logic empty, full, busy, baud_term;
   logic [31:0] status;

   assign sel       = (memAddress >= BASE_MEMORY) && (memAddress <= TOP_MEMORY);
   assign offset    = memAddress[2];
   assign push_req  = memWrite && sel && !offset && byteMask[0];
   assign ovf_clr   = memWrite && sel && offset && byteMask[0] && memWriteData[3];
   assign empty     = (count_q == '0);
   assign full      = (count_q == DEPTH_C);
   assign busy      = (state_q != IDLE);
   assign pop       = (state_q == IDLE) && !empty;
   // A push into a full FIFO still fits when the serializer takes the head this cycle.
   assign push_ok   = push_req && (!full || pop);
   assign baud_term = (baud_q == BAUD_LAST);
   assign status    = {24'd0, 4'(count_q), overflow_q, empty, full, busy};

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = 1'b1;
      case (state_q)
         IDLE: if (!empty) begin
            shift_d = fifo_q[rd_ptr_q];
            baud_d  = '0;
            state_d = START;
         end
         START: if (baud_term) begin
            baud_d  = '0;
            bit_d   = 3'd0;
            state_d = DATA;
         end else baud_d = baud_q + 1'b1;
         DATA: if (baud_term) begin
            baud_d  = '0;
            shift_d = {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) state_d = STOP;
            else               bit_d   = bit_q + 3'd1;
         end else baud_d = baud_q + 1'b1;
         STOP: if (baud_term) begin
            baud_d  = '0;
            state_d = IDLE;
         end else baud_d = baud_q + 1'b1;
         default: state_d = IDLE;
      endcase
      // tx is registered from the level of the state being entered, so it leads no edge.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= 3'd0;
         shift_q    <= 8'd0;
         tx_q       <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         read_q     <= 32'd0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
         if (push_req && !push_ok) overflow_q <= 1'b1;
         else if (ovf_clr)         overflow_q <= 1'b0;
         read_q <= (sel && offset) ? status : 32'd0;
      end
   end

   // NOTE: FIFO storage is not reset; the pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_q[wr_ptr_q] <= memWriteData[7:0];
   end

   assign memReadData = read_q;
   assign tx          = tx_q;
   assign irq_empty   = empty && (state_q == IDLE);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed framing/decoding cases plus
// randomized bursts checked against a transaction-level FIFO/frame model.
module tb_uart_tx_mmio;

   localparam int          CPB    = 4;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] BASE   = 32'hFFFF_FFE0;
   localparam logic [31:0] TXDATA = BASE;
   localparam logic [31:0] STATUS = BASE + 32'd4;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] memAddress;
   logic [31:0] memWriteData;
   logic        memWrite;
   logic [3:0]  byteMask;
   logic [31:0] memReadData;
   logic        tx;
   logic        irq_empty;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_mmio #(
      .BASE_MEMORY (BASE),
      .TOP_MEMORY  (32'hFFFF_FFE7),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .memAddress  (memAddress),
      .memWriteData(memWriteData),
      .memWrite    (memWrite),
      .byteMask    (byteMask),
      .memReadData (memReadData),
      .tx          (tx),
      .irq_empty   (irq_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] status_word(input int cnt, input bit ovf, input bit bsy);
      logic [3:0] c;
      c = cnt[3:0];
      return {24'd0, c, ovf, (cnt == 0), (cnt == DEPTH), bsy};
   endfunction

   // Expected line level k cycles after the start bit begins: start, 8 data LSB first, stop.
   function automatic logic frame_level(input logic [7:0] b, input int k);
      int lvl;
      lvl = k / CPB;
      if (lvl == 0) return 1'b0;
      if (lvl <= 8) return b[lvl-1];
      return 1'b1;
   endfunction

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
      memAddress   = addr;
      memWriteData = data;
      byteMask     = mask;
      memWrite     = 1'b1;
      @(negedge clk);
      memWrite   = 1'b0;
      memAddress = 32'd0;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
      memAddress = addr;
      memWrite   = 1'b0;
      @(negedge clk);
      data       = memReadData;
      memAddress = 32'd0;
   endtask

   // Waits (bounded) for a start bit, checks its distance from the call, every
   // cycle of the frame, and the byte recovered from mid-bit samples.
   task automatic watch_frame(input logic [7:0] b, input int exp_wait, input string tag);
      int waited = 0;
      bit found = 0;
      int bad = 0;
      logic [7:0] got_b = 8'h00;
      while (!found && waited < 200) begin
         @(negedge clk);
         waited++;
         if (tx === 1'b0) found = 1;
      end
      if (!found) begin
         check({tag, "_start_timeout"}, 32'd0, 32'd1);
         return;
      end
      check({tag, "_start_gap"}, waited, exp_wait);
      check({tag, "_irq_busy"}, {31'd0, irq_empty}, 32'd0);
      for (int k = 0; k < 10 * CPB; k++) begin
         if (k > 0) @(negedge clk);
         if (tx !== frame_level(b, k)) bad++;
         if ((k % CPB) == CPB / 2 && k / CPB >= 1 && k / CPB <= 8) got_b[k/CPB-1] = tx;
      end
      check({tag, "_levels_bad"}, bad, 32'd0);
      check({tag, "_byte"}, {24'd0, got_b}, {24'd0, b});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [7:0]  exp_q[$];
      logic [7:0]  burst[$];
      int n, cnt, lows;
      bit ovf;

      resetn = 1'b0; memAddress = 32'd0; memWriteData = 32'd0; memWrite = 1'b0; byteMask = 4'd0;
      repeat (2) @(negedge clk);

      // Reset holds outputs in place despite random bus traffic.
      for (int i = 0; i < 8; i++) begin
         memAddress   = $urandom_range(0, 1) ? BASE + 32'($urandom_range(0, 7)) : $urandom;
         memWriteData = $urandom;
         byteMask     = 4'($urandom);
         memWrite     = 1'($urandom);
         @(negedge clk);
         check("rst_tx", {31'd0, tx}, 32'd1);
         check("rst_rdata", memReadData, 32'd0);
         check("rst_irq", {31'd0, irq_empty}, 32'd1);
      end
      memWrite = 1'b0; memAddress = 32'd0; byteMask = 4'd0;
      resetn = 1'b1;
      bus_read(STATUS, d);
      check("status_after_reset", d, 32'h4);

      // Single byte.
      bus_write(TXDATA, 32'h55, 4'b0001);
      watch_frame(8'h55, 1, "single");
      @(negedge clk);
      check("single_tx_idle", {31'd0, tx}, 32'd1);
      check("single_irq_after", {31'd0, irq_empty}, 32'd1);

      // Burst of six from IDLE: one goes straight to the serializer, four queue, one drops.
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07};
      fork
         begin
            for (int i = 1; i <= 6; i++) bus_write(TXDATA, 32'(i), 4'b0001);
            bus_read(STATUS, d);
            check("burst_status", d, status_word(4, 1'b1, 1'b1));
            bus_write(STATUS, 32'h8, 4'b0001);
            bus_read(STATUS, d);
            check("ovf_cleared", d, status_word(4, 1'b0, 1'b1));
            // Land the next push on the edge where frame 1 ends and byte 2 is popped.
            repeat (33) @(negedge clk);
            bus_write(TXDATA, 32'h07, 4'b0001);
            bus_read(STATUS, d);
            check("push_in_pop_cycle", d, status_word(4, 1'b0, 1'b1));
         end
         begin
            foreach (exp_q[i]) watch_frame(exp_q[i], 2, $sformatf("burst%0d", i));
         end
      join
      @(negedge clk);
      check("burst_irq_done", {31'd0, irq_empty}, 32'd1);
      bus_read(STATUS, d);
      check("burst_status_done", d, 32'h4);

      // Randomized bursts against the model: first byte pops, DEPTH queue, rest drop.
      for (int r = 0; r < 5; r++) begin
         n = $urandom_range(1, DEPTH + 2);
         burst.delete();
         exp_q.delete();
         for (int i = 0; i < n; i++) burst.push_back(8'($urandom));
         for (int i = 0; i < n && i < DEPTH + 1; i++) exp_q.push_back(burst[i]);
         ovf = (n > DEPTH + 1);
         cnt = (n - 1 < DEPTH) ? n - 1 : DEPTH;
         fork
            begin
               foreach (burst[i]) bus_write(TXDATA, {$urandom, burst[i]} >> 0 & 32'hFF | 32'(burst[i]), 4'b0001);
               @(negedge clk);
               bus_read(STATUS, d);
               check($sformatf("rnd%0d_status", r), d, status_word(cnt, ovf, 1'b1));
            end
            begin
               foreach (exp_q[i]) watch_frame(exp_q[i], 2, $sformatf("rnd%0d_f%0d", r, i));
            end
         join
         @(negedge clk);
         check($sformatf("rnd%0d_irq", r), {31'd0, irq_empty}, 32'd1);
         bus_read(STATUS, d);
         check($sformatf("rnd%0d_idle", r), d, status_word(0, ovf, 1'b0));
         bus_write(STATUS, $urandom | 32'h8, 4'b0001);
         bus_read(STATUS, d);
         check($sformatf("rnd%0d_clr", r), d, 32'h4);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      // Read latency and address decode.
      memAddress = STATUS;
      @(negedge clk);
      check("lat_status", memReadData, 32'h4);
      memAddress = 32'h0000_0010;
      @(negedge clk);
      check("lat_unsel", memReadData, 32'h0);
      bus_read(32'hFFFF_FFE7, d); check("dec_top", d, 32'h4);
      bus_read(32'hFFFF_FFE8, d); check("dec_above", d, 32'h0);
      bus_read(32'hFFFF_FFDC, d); check("dec_below", d, 32'h0);
      bus_read(32'hFFFF_FFE3, d); check("dec_txdata", d, 32'h0);

      // Writes that must not push.
      bus_write(TXDATA, 32'hFFFF_FFA5, 4'b1110);
      check("mask_irq", {31'd0, irq_empty}, 32'd1);
      bus_write(32'hFFFF_FFE8, 32'hA5, 4'b0001);
      check("outside_irq", {31'd0, irq_empty}, 32'd1);
      bus_read(STATUS, d);
      check("nopush_status", d, 32'h4);

      // Reset mid-frame during data bit 3 of 0xF0 (a low bit).
      bus_write(TXDATA, 32'hF0, 4'b0001);
      @(negedge clk);
      check("mid_start", {31'd0, tx}, 32'd0);
      bus_write(TXDATA, 32'h11, 4'b0001);
      bus_write(TXDATA, 32'h22, 4'b0001);
      repeat (15) @(negedge clk);
      check("mid_bit3_low", {31'd0, tx}, 32'd0);
      #2 resetn = 1'b0;
      #1;
      check("mid_async_tx", {31'd0, tx}, 32'd1);
      check("mid_async_irq", {31'd0, irq_empty}, 32'd1);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      bus_read(STATUS, d);
      check("mid_status", d, 32'h4);
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check("mid_no_tx", lows, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
